// File: rtl/wrapper_8bit_sha_256.sv
// ---------------------------------------------------------------------------
// wrapper_8bit_sha_256
// Tiny Tapeout top that hashes one host-padded 512-bit SHA-256 block through
// an 8-bit interface. The host streams 64 bytes, pulses start, waits for done
// and then reads the 32-byte digest one byte at a time.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high, overrides everything
//   ena      design-select; while low all state holds
//   ui_in    message byte for the load strobe
//   uio_in   [0] wr, [1] start, [2] rd; [7:3] unused
//   uo_out   digest byte at the read pointer while done, else 0x00
//   uio_out  [3] busy, [4] done, [5] full; other bits 0
//   uio_oe   constant 8'b0011_1000
// ---------------------------------------------------------------------------
module wrapper_8bit_sha_256 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // StLatch registers the first digest byte so uo_out is valid as done rises.
    typedef enum logic [2:0] {StLoad, StRound, StFinal, StLatch, StDone} state_e;

    state_e      state_q;
    logic [6:0]  cnt_q;
    logic [5:0]  round_q;
    logic [4:0]  ptr_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  out_q;
    // w_q is the message buffer during load and the schedule window during rounds.
    logic [31:0] w_q  [16];
    // hv_q holds a..h during rounds and H0..H7 once the final add is done.
    logic [31:0] hv_q [8];

    logic wr, start, rd;
    logic unused_uio;
    assign wr         = uio_in[0];
    assign start      = uio_in[1];
    assign rd         = uio_in[2];
    assign unused_uio = ^uio_in[7:3];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [4:0]  lane_sh;
    logic [4:0]  ptr_nx;
    logic [4:0]  rd_sh;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [31:0] s0, s1, ch, maj, t1, t2, sig0, sig1, w_new;

    always_comb begin
        // Big-endian lane: byte 0 of a word sits in bits [31:24].
        lane_sh = {~cnt_q[1:0], 3'b000};
        ptr_nx  = ptr_q + 5'd1;
        rd_sh   = {~ptr_nx[1:0], 3'b000};
        rd_word = hv_q[ptr_nx[4:2]];
        rd_byte = rd_word[rd_sh +: 8];

        s1    = rotr(hv_q[4], 6) ^ rotr(hv_q[4], 11) ^ rotr(hv_q[4], 25);
        ch    = (hv_q[4] & hv_q[5]) ^ (~hv_q[4] & hv_q[6]);
        t1    = hv_q[7] + s1 + ch + K[round_q] + w_q[0];
        s0    = rotr(hv_q[0], 2) ^ rotr(hv_q[0], 13) ^ rotr(hv_q[0], 22);
        maj   = (hv_q[0] & hv_q[1]) ^ (hv_q[0] & hv_q[2]) ^ (hv_q[1] & hv_q[2]);
        t2    = s0 + maj;
        sig0  = rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3);
        sig1  = rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10);
        // Window slot 0 is always W[t]; the word entering slot 15 is W[t+16].
        w_new = sig1 + w_q[9] + sig0 + w_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            round_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else if (ena) begin
            unique case (state_q)
                StLoad: begin
                    if (wr) begin
                        if (!cnt_q[6]) begin
                            w_q[cnt_q[5:2]][lane_sh +: 8] <= ui_in;
                            cnt_q <= cnt_q + 7'd1;
                        end
                    end else if (start && cnt_q[6]) begin
                        state_q <= StRound;
                        busy_q  <= 1'b1;
                        round_q <= '0;
                        for (int i = 0; i < 8; i++) hv_q[i] <= IV[i];
                    end
                end
                StRound: begin
                    hv_q[0] <= t1 + t2;
                    hv_q[1] <= hv_q[0];
                    hv_q[2] <= hv_q[1];
                    hv_q[3] <= hv_q[2];
                    hv_q[4] <= hv_q[3] + t1;
                    hv_q[5] <= hv_q[4];
                    hv_q[6] <= hv_q[5];
                    hv_q[7] <= hv_q[6];
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
                    w_q[15] <= w_new;
                    round_q <= round_q + 6'd1;
                    if (round_q == 6'd63) state_q <= StFinal;
                end
                StFinal: begin
                    for (int i = 0; i < 8; i++) hv_q[i] <= hv_q[i] + IV[i];
                    state_q <= StLatch;
                end
                StLatch: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    ptr_q   <= '0;
                    out_q   <= hv_q[0][31:24];
                    state_q <= StDone;
                end
                StDone: begin
                    if (wr) begin
                        w_q[0][31:24] <= ui_in;
                        cnt_q   <= 7'd1;
                        done_q  <= 1'b0;
                        out_q   <= '0;
                        state_q <= StLoad;
                    end else if (rd) begin
                        ptr_q <= ptr_nx;
                        out_q <= rd_byte;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign uo_out  = out_q;
    assign uio_out = {2'b00, cnt_q[6], done_q, busy_q, 3'b000};
    assign uio_oe  = 8'b0011_1000;

endmodule

// File: tb/tb_wrapper_8bit_sha_256.sv
module tb_wrapper_8bit_sha_256;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic [511:0] blk_abc;
    logic [511:0] blk_empty;

    wrapper_8bit_sha_256 dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [511:0] b);
        for (int i = 0; i < 64; i++) begin
            ui_in  = b[511 - 8 * i -: 8];
            uio_in = 8'h01;
            tick();
        end
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic pulse_start();
        uio_in = 8'h02;
        tick();
        uio_in = 8'h00;
    endtask

    // Cycles from the start edge to the first cycle with done high; 300 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (uio_out[4] !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic read_digest(output logic [255:0] d);
        for (int i = 0; i < 32; i++) begin
            d[255 - 8 * i -: 8] = uo_out;
            uio_in = 8'h04;
            tick();
            uio_in = 8'h00;
        end
    endtask

    task automatic test_reset();
        ena    = 1'b1;
        rst    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        n_tests++;
        if (uio_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uio_out: got %h expected 00", uio_out);
        end
        n_tests++;
        if (uio_oe !== 8'h38) begin
            n_fail++;
            $display("FAIL reset_uio_oe: got %h expected 38", uio_oe);
        end
        pulse_start();
        tick();
        n_tests++;
        if (uio_out[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_when_empty_busy: got %b expected 0", uio_out[3]);
        end
    endtask

    task automatic test_abc();
        int cyc;
        logic [255:0] d;
        load_block(blk_abc);
        n_tests++;
        if (uio_out[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL abc_full: got %b expected 1", uio_out[5]);
        end
        pulse_start();
        n_tests++;
        if (uio_out[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL abc_busy: got %b expected 1", uio_out[3]);
        end
        wait_done(cyc);
        n_tests++;
        if (cyc !== 66) begin
            n_fail++;
            $display("FAIL abc_latency: got %0d expected 66", cyc);
        end
        n_tests++;
        if (uio_out[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL abc_busy_at_done: got %b expected 0", uio_out[3]);
        end
        read_digest(d);
        n_tests++;
        if (d !== DIG_ABC) begin
            n_fail++;
            $display("FAIL abc_digest: got %h expected %h", d, DIG_ABC);
        end
    endtask

    task automatic test_empty();
        int cyc;
        logic [255:0] d;
        load_block(blk_empty);
        pulse_start();
        wait_done(cyc);
        n_tests++;
        if (cyc !== 66) begin
            n_fail++;
            $display("FAIL empty_latency: got %0d expected 66", cyc);
        end
        read_digest(d);
        n_tests++;
        if (d !== DIG_EMPTY) begin
            n_fail++;
            $display("FAIL empty_digest: got %h expected %h", d, DIG_EMPTY);
        end
    endtask

    task automatic test_overflow_wrap();
        int cyc;
        logic [255:0] d;
        load_block(blk_abc);
        ui_in  = 8'hff;
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
        n_tests++;
        if (uio_out[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_full: got %b expected 1", uio_out[5]);
        end
        pulse_start();
        wait_done(cyc);
        read_digest(d);
        n_tests++;
        if (d !== DIG_ABC) begin
            n_fail++;
            $display("FAIL overflow_digest: got %h expected %h", d, DIG_ABC);
        end
        // 32 reads already done; the 33rd lands on byte 1.
        uio_in = 8'h04;
        tick();
        uio_in = 8'h00;
        n_tests++;
        if (uo_out !== 8'h78) begin
            n_fail++;
            $display("FAIL wrap_byte1: got %h expected 78", uo_out);
        end
    endtask

    task automatic test_ena_gating();
        int cyc;
        int rest;
        logic [255:0] d;
        load_block(blk_abc);
        pulse_start();
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
        end
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cyc++;
        end
        ena = 1'b1;
        wait_done(rest);
        cyc += rest;
        n_tests++;
        if (cyc !== 76) begin
            n_fail++;
            $display("FAIL ena_latency: got %0d expected 76", cyc);
        end
        read_digest(d);
        n_tests++;
        if (d !== DIG_ABC) begin
            n_fail++;
            $display("FAIL ena_digest: got %h expected %h", d, DIG_ABC);
        end
    endtask

    task automatic test_abort_restart();
        int cyc;
        logic [255:0] d;
        load_block(blk_abc);
        pulse_start();
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (uio_out[4] !== 1'b0 || uio_out[5] !== 1'b0 || uio_out[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags: got uio_out %h expected 00", uio_out);
        end
        load_block(blk_abc);
        pulse_start();
        wait_done(cyc);
        n_tests++;
        if (cyc !== 66) begin
            n_fail++;
            $display("FAIL abort_latency: got %0d expected 66", cyc);
        end
        read_digest(d);
        n_tests++;
        if (d !== DIG_ABC) begin
            n_fail++;
            $display("FAIL abort_digest: got %h expected %h", d, DIG_ABC);
        end
        // Load straight out of DONE: the first wr becomes byte 0 of the new block.
        load_block(blk_abc);
        n_tests++;
        if (uio_out[4] !== 1'b0 || uio_out[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_flags: got done %b full %b expected 0 1",
                     uio_out[4], uio_out[5]);
        end
        pulse_start();
        wait_done(cyc);
        read_digest(d);
        n_tests++;
        if (d !== DIG_ABC) begin
            n_fail++;
            $display("FAIL reload_digest: got %h expected %h", d, DIG_ABC);
        end
    endtask

    initial begin
        blk_abc   = {32'h61626380, 416'h0, 64'h18};
        blk_empty = {8'h80, 504'h0};
        test_reset();
        test_abc();
        test_empty();
        test_overflow_wrap();
        test_ena_gating();
        test_abort_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
